// File: rtl/hps_bus_master.sv
// hps_bus_master: initiator of the 16-bit HPS command bus (command word + N data words, reply capture).
// Optional macro HPS_MASTER_TIMEOUT_EN adds an io_wait timeout that aborts with an err pulse.
module hps_bus_master #(
    parameter int STROBE_GAP = 3,
    parameter int SETTLE     = 2
`ifdef HPS_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_code,
    input  logic [9:0]  cmd_len,
    input  logic        cmd_rd,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        io_enable,
    output logic        io_strobe,
    output logic [15:0] io_din,
    input  logic [15:0] io_dout,
    input  logic        io_wait,
    input  logic        io_wide
);
    localparam int GW = $clog2(STROBE_GAP);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, SETUP, CMD, GAP, DATA, END} state_t;

    state_t        state, nxt;
    logic [15:0]   code_q;
    logic [9:0]    rem;
    logic          rd_q;
    logic          last_data;
    logic [GW-1:0] gcnt;
    logic [SW-1:0] scnt;
    logic [15:0]   wide_mask;
    logic          accept, cmd_go, data_go, gap_last, settled, tmo;

    // Strobes are registered: io_wait is sampled the cycle before the strobe appears
    assign accept    = cmd_ready & cmd_valid;
    assign cmd_go    = (state == CMD) & ~io_wait;
    assign data_go   = (state == DATA) & ~io_wait & (rd_q | wr_valid);
    assign gap_last  = (state == GAP) & (gcnt == GW'(STROBE_GAP - 2));
    assign settled   = scnt == SW'(SETTLE - 1);
    assign wide_mask = {{8{io_wide}}, 8'hFF};

`ifdef HPS_MASTER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wcnt;
    logic          stalled;
    assign stalled = ((state == CMD) | (state == DATA)) & io_wait;
    assign tmo     = stalled & (wcnt == WW'(TIMEOUT_CYC - 1));

    // Count consecutive stalled cycles; abort pulse when the limit is reached
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wcnt <= '0;
            err  <= 1'b0;
        end else begin
            wcnt <= (stalled & ~tmo) ? wcnt + 1'b1 : '0;
            err  <= tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    // Next-state logic; a timeout overrides everything and closes the transaction
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = SETUP;
            SETUP:   nxt = CMD;
            CMD:     if (cmd_go) nxt = GAP;
            GAP:     if (gap_last) nxt = (rem == '0) ? END : DATA;
            DATA:    if (data_go) nxt = GAP;
            END:     if (settled) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (tmo) nxt = END;
    end

    // Bus outputs, handshakes, counters and transaction registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            io_enable <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= '0;
            code_q    <= '0;
            rem       <= '0;
            rd_q      <= 1'b0;
            last_data <= 1'b0;
            gcnt      <= '0;
            scnt      <= '0;
        end else begin
            cmd_ready <= nxt == IDLE;
            io_strobe <= cmd_go | data_go;
            wr_ready  <= data_go & ~rd_q;
            rd_valid  <= gap_last & last_data;
            done      <= (state == END) & (scnt == '0);
            gcnt      <= ((state == GAP) & ~gap_last) ? gcnt + 1'b1 : '0;
            scnt      <= (state == END) ? scnt + 1'b1 : '0;
            if (accept) begin
                code_q <= cmd_code;
                rem    <= cmd_len;
                rd_q   <= cmd_rd;
            end
            if (state == SETUP) io_enable <= 1'b1;
            if (state == END)   io_enable <= 1'b0;
            if (cmd_go) begin
                io_din    <= code_q & wide_mask;
                last_data <= 1'b0;
            end
            if (data_go) begin
                io_din    <= rd_q ? 16'h0000 : (wr_data & wide_mask);
                rem       <= rem - 1'b1;
                last_data <= 1'b1;
            end
            if (gap_last & last_data) rd_data <= io_dout & wide_mask;
        end
    end
endmodule

// File: tb/tb_hps_bus_master.sv
// tb_hps_bus_master: directed self-checking bench for hps_bus_master.
module tb_hps_bus_master;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_rd = 1'b0, wr_valid = 1'b0;
    logic        io_wait = 1'b0, io_wide = 1'b1;
    logic [15:0] cmd_code = '0, wr_data = '0, io_dout = '0;
    logic [9:0]  cmd_len = '0;
    logic        cmd_ready, wr_ready, rd_valid, done, err, io_enable, io_strobe;
    logic [15:0] rd_data, io_din;

    hps_bus_master dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_rd(cmd_rd), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .io_enable(io_enable), .io_strobe(io_strobe), .io_din(io_din),
        .io_dout(io_dout), .io_wait(io_wait), .io_wide(io_wide)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int stimes[$];
    logic [15:0] sdin[$], rvals[$], wq[$], rq[$];
    int n_wr, done_t, ready_t, err_t, en_low, rdy_busy, t0;
    logic en_at_done;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [15:0] code, input logic [9:0] len, input logic rd, input int wait_after);
        int widx, wcd, whold;
        widx = 0; wcd = 0; whold = 0;
        stimes.delete(); sdin.delete(); rvals.delete();
        n_wr = 0; done_t = -1; ready_t = -1; err_t = -1; en_low = 0; rdy_busy = 0; en_at_done = 1'b1;
        wr_valid = !rd && wq.size() > 0;
        if (wq.size() > 0) wr_data = wq[0];
        cmd_code = code; cmd_len = len; cmd_rd = rd; cmd_valid = 1'b1;
        tick;
        t0 = cyc;
        for (int k = 0; k < 6000 && done_t < 0; k++) begin
            tick;
            if (whold > 0) begin
                whold--;
                if (whold == 0) io_wait = 1'b0;
            end
            if (wcd > 0) begin
                wcd--;
                if (wcd == 0) begin
                    io_wait = 1'b1;
                    whold = 10;
                end
            end
            if (io_strobe) begin
                stimes.push_back(cyc - t0);
                sdin.push_back(io_din);
                if (stimes.size() > 1 && stimes.size() - 1 <= rq.size()) io_dout = rq[stimes.size() - 2];
                if (stimes.size() - 1 == wait_after) wcd = 2;
            end
            if (wr_ready) begin
                n_wr++;
                widx++;
                if (widx < wq.size()) wr_data = wq[widx];
                else wr_valid = 1'b0;
            end
            if (rd_valid) rvals.push_back(rd_data);
            if (err) err_t = cyc - t0;
            if (cmd_ready) rdy_busy++;
            if (done) begin
                done_t = cyc - t0;
                en_at_done = io_enable;
            end else if (!io_enable) en_low++;
        end
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        for (int k = 0; k < 10 && !cmd_ready; k++) tick;
        if (cmd_ready) ready_t = cyc - t0;
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("reset_outputs", {cmd_ready, wr_ready, rd_data, rd_valid, done, err, io_enable, io_strobe, io_din}, '0);
        reset_n = 1'b1;
        tick;
        chk("ready_after_reset", cmd_ready, 1);

        // 1: write burst of two words
        wq = '{16'h1234, 16'h5678}; rq = '{16'hAAAA, 16'h5555};
        run(16'h001e, 10'd2, 1'b0, -1);
        chk("t1_nstrobe", stimes.size(), 3);
        chk("t1_s0", stimes[0], 2);
        chk("t1_s1", stimes[1], 5);
        chk("t1_s2", stimes[2], 8);
        chk("t1_din0", sdin[0], 16'h001e);
        chk("t1_din1", sdin[1], 16'h1234);
        chk("t1_din2", sdin[2], 16'h5678);
        chk("t1_nwr", n_wr, 2);
        chk("t1_nrd", rvals.size(), 2);
        chk("t1_rd0", rvals[0], 16'hAAAA);
        chk("t1_rd1", rvals[1], 16'h5555);
        chk("t1_done_t", done_t, 11);
        chk("t1_ready_t", ready_t, 12);
        chk("t1_en_low", en_low, 0);
        chk("t1_en_at_done", en_at_done, 0);
        chk("t1_busy_ready", rdy_busy, 0);

        // 2: read of three words
        wq.delete(); rq = '{16'h0A05, 16'h0010, 16'h0000};
        run(16'h0016, 10'd3, 1'b1, -1);
        chk("t2_nstrobe", stimes.size(), 4);
        chk("t2_din0", sdin[0], 16'h0016);
        chk("t2_din_data", {sdin[1], sdin[2], sdin[3]}, 48'h0);
        chk("t2_nwr", n_wr, 0);
        chk("t2_nrd", rvals.size(), 3);
        chk("t2_rd", {rvals[0], rvals[1], rvals[2]}, 48'h0A05_0010_0000);
        chk("t2_done_t", done_t, 14);

        // 3: zero-length command
        wq.delete(); rq.delete();
        run(16'h0053, 10'd0, 1'b0, -1);
        chk("t3_nstrobe", stimes.size(), 1);
        chk("t3_din0", sdin[0], 16'h0053);
        chk("t3_nrd", rvals.size(), 0);
        chk("t3_nwr", n_wr, 0);
        chk("t3_done_t", done_t, 5);
        chk("t3_ready_t", ready_t, 6);

        // 4: io_wait high 10 cycles before the 2nd data strobe
        wq = '{16'h1111, 16'h2222, 16'h3333}; rq = '{16'h0001, 16'h0002, 16'h0003};
        run(16'h001e, 10'd3, 1'b0, 1);
        chk("t4_s1", stimes[1], 5);
        chk("t4_s2", stimes[2], 18);
        chk("t4_s3", stimes[3], 21);
        chk("t4_din2", sdin[2], 16'h2222);
        chk("t4_en_low", en_low, 0);
        chk("t4_done_t", done_t, 24);
        chk("t4_rd2", rvals[1], 16'h0002);

        // 5: narrow responder
        io_wide = 1'b0;
        wq = '{16'hABCD}; rq = '{16'hFFFF};
        run(16'h001e, 10'd1, 1'b0, -1);
        chk("t5_din1", sdin[1], 16'h00CD);
        chk("t5_rd0", rvals[0], 16'h00FF);
        io_wide = 1'b1;

        // Maximum length read
        wq.delete(); rq.delete();
        run(16'h0016, 10'd1023, 1'b1, -1);
        chk("len1023_nstrobe", stimes.size(), 1024);
        chk("len1023_nrd", rvals.size(), 1023);
        chk("len1023_done_t", done_t, 3074);

        // 6: asynchronous reset in the middle of a stalled data phase
        wq.delete();
        cmd_code = 16'h001e; cmd_len = 10'd2; cmd_rd = 1'b0; wr_valid = 1'b0; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick;
        chk("t6_enable_before", io_enable, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {cmd_ready, wr_ready, rd_data, rd_valid, done, err, io_enable, io_strobe, io_din}, '0);
        tick;
        reset_n = 1'b1;
        tick;
        chk("t6_ready_after", {cmd_ready, io_enable}, 2'b10);

`ifdef HPS_MASTER_TIMEOUT_EN
        // Timeout abort with io_wait stuck high
        wq.delete(); rq.delete();
        io_wait = 1'b1;
        run(16'h0054, 10'd1, 1'b0, -1);
        io_wait = 1'b0;
        chk("tmo_nstrobe", stimes.size(), 0);
        chk("tmo_err_t", err_t, 4097);
        chk("tmo_done_t", done_t, 4098);
        chk("tmo_en_at_done", en_at_done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
